// File: rtl/sps_burst_counter.sv
// rtl/sps_burst_counter.sv - programmable up/down event counter for the SPS burst datapath
// FREE/MOD/SAT count modes plus a self-terminating BURST mode with start/busy/done handshake.
module sps_burst_counter #(
   parameter int COUNTER_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     clr,
   input  logic                     load,
   input  logic [COUNTER_WIDTH-1:0] load_val,
   input  logic                     dir,
   input  logic [1:0]               mode,
   input  logic [COUNTER_WIDTH-1:0] limit,
   input  logic                     start,
   output logic [COUNTER_WIDTH-1:0] counter_out,
   output logic                     tc,
   output logic                     busy,
   output logic                     done
);

   localparam logic [1:0] MODE_FREE  = 2'b00;
   localparam logic [1:0] MODE_MOD   = 2'b01;
   localparam logic [1:0] MODE_SAT   = 2'b10;
   localparam logic [1:0] MODE_BURST = 2'b11;

   localparam logic [COUNTER_WIDTH-1:0] CNT_ZERO = '0;
   localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = '1;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t                     state_q, state_d;
   logic [COUNTER_WIDTH-1:0]   cnt_q, cnt_d;
   logic                       tc_q, tc_d;
   logic                       busy_q, busy_d;
   logic                       done_q, done_d;

   logic [COUNTER_WIDTH-1:0]   cnt_inc, cnt_dec, cnt_step, burst_end;
   logic                       start_ok;

   assign cnt_inc   = cnt_q + CNT_ONE;
   assign cnt_dec   = cnt_q - CNT_ONE;
   assign cnt_step  = dir ? cnt_dec : cnt_inc;
   assign burst_end = dir ? CNT_ZERO : limit;
   // start only matters when a burst could actually begin; otherwise a step may proceed
   assign start_ok  = start && (mode == MODE_BURST) && (state_q == S_IDLE);

   always_comb begin
      cnt_d   = cnt_q;
      tc_d    = 1'b0;
      done_d  = 1'b0;
      state_d = state_q;

      // leaving BURST mode abandons a running burst silently
      if (mode != MODE_BURST) begin
         state_d = S_IDLE;
      end

      if (clr) begin
         cnt_d   = CNT_ZERO;
         state_d = S_IDLE;
      end else if (load) begin
         cnt_d = load_val;
      end else if (start_ok) begin
         cnt_d = dir ? limit : CNT_ZERO;
         if (limit == CNT_ZERO) begin
            done_d = 1'b1;
         end else begin
            state_d = S_RUN;
         end
      end else if (en) begin
         case (mode)
            MODE_FREE: begin
               cnt_d = cnt_step;
               tc_d  = dir ? (cnt_q == CNT_ZERO) : (cnt_q == CNT_MAX);
            end
            MODE_MOD: begin
               if (!dir) begin
                  if (cnt_q >= limit) begin
                     cnt_d = CNT_ZERO;
                     tc_d  = 1'b1;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  if ((cnt_q == CNT_ZERO) || (cnt_q > limit)) begin
                     cnt_d = limit;
                     tc_d  = 1'b1;
                  end else begin
                     cnt_d = cnt_dec;
                  end
               end
            end
            MODE_SAT: begin
               if (!dir) begin
                  if (cnt_q < limit) begin
                     cnt_d = cnt_inc;
                     tc_d  = (cnt_inc == limit);
                  end
               end else begin
                  if (cnt_q != CNT_ZERO) begin
                     cnt_d = cnt_dec;
                     tc_d  = (cnt_q == CNT_ONE);
                  end
               end
            end
            default: begin
               if (state_q == S_RUN) begin
                  cnt_d = cnt_step;
                  if (cnt_step == burst_end) begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                     tc_d    = 1'b1;
                  end
               end
            end
         endcase
      end

      busy_d = (state_d == S_RUN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= CNT_ZERO;
         tc_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tc_q    <= tc_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign counter_out = cnt_q;
   assign tc          = tc_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_sps_burst_counter.sv
// tb/tb_sps_burst_counter.sv - directed self-checking bench for sps_burst_counter
module tb_sps_burst_counter;

   logic       clk = 1'b0;
   logic       rst;
   logic       en, clr, load, dir, start;
   logic [7:0] load_val, limit;
   logic [1:0] mode;
   logic [7:0] counter_out;
   logic       tc, busy, done;

   int n_vec = 0;
   int n_err = 0;

   sps_burst_counter #(.COUNTER_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
      .dir(dir), .mode(mode), .limit(limit), .start(start),
      .counter_out(counter_out), .tc(tc), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk(input string tag, input int c, input int b, input int d, input int t);
      check({tag, ".cnt"},  32'(counter_out), 32'(c));
      check({tag, ".busy"}, 32'(busy),        32'(b));
      check({tag, ".done"}, 32'(done),        32'(d));
      check({tag, ".tc"},   32'(tc),          32'(t));
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; en = 0; clr = 0; load = 0; dir = 0; start = 0;
      load_val = 8'd0; limit = 8'd0; mode = 2'b00;
      #1;
      chk("reset", 0, 0, 0, 0);
      tick;
      #2 rst = 1'b0;
      tick;

      // FREE up: full wrap, tc only on 255->0
      mode = 2'b00; en = 1;
      for (int k = 1; k <= 256; k++) begin
         tick;
         check("free_up.cnt", 32'(counter_out), 32'(k % 256));
         check("free_up.tc",  32'(tc),          32'(k == 256));
      end
      dir = 1;
      tick;
      chk("free_dn_wrap", 255, 0, 0, 1);
      en = 0;
      tick;
      chk("free_hold", 255, 0, 0, 0);

      // modulo mode, limit=5
      clr = 1;
      tick;
      chk("clr", 0, 0, 0, 0);
      clr = 0; mode = 2'b01; limit = 8'd5; dir = 0; en = 1;
      for (int k = 1; k <= 12; k++) begin
         tick;
         check("mod_up.cnt", 32'(counter_out), 32'(k % 6));
         check("mod_up.tc",  32'(tc),          32'((k % 6) == 0));
      end
      en = 0; load = 1; load_val = 8'd9;
      tick;
      chk("mod_load", 9, 0, 0, 0);
      load = 0; en = 1; dir = 1;
      tick;
      chk("mod_dn_above", 5, 0, 0, 1);
      tick;
      chk("mod_dn", 4, 0, 0, 0);

      // SAT limit=3
      en = 0; clr = 1;
      tick;
      clr = 0; mode = 2'b10; limit = 8'd3; dir = 0; en = 1;
      for (int k = 1; k <= 6; k++) begin
         tick;
         check("sat_up.cnt", 32'(counter_out), 32'((k < 3) ? k : 3));
         check("sat_up.tc",  32'(tc),          32'(k == 3));
      end
      dir = 1;
      tick; chk("sat_dn2", 2, 0, 0, 0);
      tick; chk("sat_dn1", 1, 0, 0, 0);
      tick; chk("sat_dn0", 0, 0, 0, 1);
      tick; chk("sat_hold0", 0, 0, 0, 0);

      // BURST limit=4 up, en held
      mode = 2'b11; limit = 8'd4; dir = 0; en = 1; start = 1;
      tick;
      chk("b4_start", 0, 1, 0, 0);
      start = 0;
      for (int k = 1; k <= 4; k++) begin
         tick;
         chk("b4_step", k, (k < 4) ? 1 : 0, (k == 4) ? 1 : 0, (k == 4) ? 1 : 0);
      end
      tick;
      chk("b4_after", 4, 0, 0, 0);

      // BURST with en gaps and an ignored start, then back-to-back start
      start = 1;
      tick; chk("bg_start", 0, 1, 0, 0);
      start = 0;
      tick; chk("bg_s1", 1, 1, 0, 0);
      en = 0; start = 1;
      tick; chk("bg_ign_start", 1, 1, 0, 0);
      start = 0;
      tick; chk("bg_gap", 1, 1, 0, 0);
      en = 1;
      tick; chk("bg_s2", 2, 1, 0, 0);
      tick; chk("bg_s3", 3, 1, 0, 0);
      tick; chk("bg_done", 4, 0, 1, 1);
      start = 1;
      tick; chk("b2b_start", 0, 1, 0, 0);
      start = 0;
      tick; chk("b2b_s1", 1, 1, 0, 0);
      clr = 1;
      tick; chk("b_clr", 0, 0, 0, 0);
      clr = 0;
      tick; chk("b_clr_idle", 0, 0, 0, 0);

      // BURST limit=3 down
      limit = 8'd3; dir = 1; start = 1;
      tick; chk("bd_start", 3, 1, 0, 0);
      start = 0;
      tick; chk("bd_s2", 2, 1, 0, 0);
      tick; chk("bd_s1", 1, 1, 0, 0);
      tick; chk("bd_done", 0, 0, 1, 1);

      // BURST limit=0: immediate done, no busy
      dir = 0; limit = 8'd0; start = 1;
      tick; chk("b0_start", 0, 0, 1, 0);
      start = 0;
      tick; chk("b0_after", 0, 0, 0, 0);

      // leaving BURST mode mid-run
      limit = 8'd4; start = 1;
      tick; chk("bm_start", 0, 1, 0, 0);
      start = 0;
      tick; chk("bm_s1", 1, 1, 0, 0);
      mode = 2'b00; en = 0;
      tick; chk("bm_leave", 1, 0, 0, 0);
      mode = 2'b11; en = 1;
      tick; chk("bm_idle_hold", 1, 0, 0, 0);

      // async reset between edges during RUN
      start = 1;
      tick; chk("br_start", 0, 1, 0, 0);
      start = 0;
      tick; chk("br_s1", 1, 1, 0, 0);
      #2 rst = 1'b1;
      #1 chk("async_rst", 0, 0, 0, 0);
      tick; chk("rst_held", 0, 0, 0, 0);
      #2 rst = 1'b0;
      tick; chk("rst_rel", 0, 0, 0, 0);

      // clr beats load and start
      mode = 2'b00; en = 0; load = 1; load_val = 8'd7;
      tick; chk("pri_load", 7, 0, 0, 0);
      mode = 2'b11; clr = 1; start = 1;
      tick; chk("pri_clr", 0, 0, 0, 0);
      clr = 0; load = 0; start = 0;
      tick; chk("pri_after", 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sps_burst_counter.md
# sps_burst_counter

Parametrised up/down event counter for the SPS burst datapath. It succeeds the fixed 4-bit enable counter with programmable width, direction, terminal limit, load/clear and four count modes, one of which is a self-terminating burst with a start/busy/done handshake. It sits between the burst controller and the pulse/address generators: it counts enabled cycles and flags terminal events.

## Interface
- COUNTER_WIDTH, 8, width of counter, load value and limit (≥2)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  step enable; one step per cycle while high
- clr  in  1  synchronous clear
- load  in  1  synchronous load of load_val
- load_val  in  COUNTER_WIDTH  value for load
- dir  in  1  0 = count up, 1 = count down
- mode  in  2  00 FREE, 01 MOD, 10 SAT, 11 BURST
- limit  in  COUNTER_WIDTH  terminal value for MOD/SAT/BURST
- start  in  1  burst start request (BURST mode only)
- counter_out  out  COUNTER_WIDTH  current count (registered)
- tc  out  1  terminal-count pulse (registered)
- busy  out  1  burst in progress (registered)
- done  out  1  burst-complete pulse (registered)

## Operation
- Reset: counter_out=0, tc=0, busy=0, done=0, FSM=IDLE.
- Priority per edge: rst > clr > load > start > step. clr: count=0, FSM=IDLE, busy=0, no tc/done. load: count=load_val, FSM state unchanged, no tc.
- A step occurs only when en=1 and no higher-priority action. In BURST mode a step also requires FSM=RUN.
- All arithmetic modulo 2^COUNTER_WIDTH; no carry out.
- FREE: up/down ±1, natural wrap (max→0, 0→max). tc on wrap step.
- MOD: up: count≥limit → 0 (tc), else +1. Down: count=0 or count>limit → limit (tc), else −1.
- SAT: up: count≥limit holds (no tc), count+1=limit raises tc. Down: count=0 holds, step 1→0 raises tc. tc fires once on arrival, not while holding.
- BURST FSM, states IDLE, RUN:
  - IDLE + start: count = 0 (dir=0) or limit (dir=1). If limit=0, stay IDLE and pulse done; otherwise → RUN, busy=1.
  - RUN + step: ±1. If the new value equals end (limit up, 0 down): → IDLE, busy=0, done=1, tc=1; count holds end value.
  - start while RUN ignored. load in RUN changes count only; termination is checked on steps only.
  - mode leaving 11 while RUN: → IDLE, busy=0, no done. dir must be static while busy; a change there is undefined.
- Outside BURST, start is ignored and FSM stays IDLE.

## Timing
- Every output is registered and visible the cycle after the causing edge; there is no combinational input→output path.
- tc and done are single-cycle pulses. tc and done assert together on burst completion.
- Burst of limit=N (N≥1) with en held high: start at edge 0, busy high from edge 0 to edge N, done high for the cycle after edge N. Latency is N+1 cycles from start to done.
- A new start is accepted on the cycle done is high, so back-to-back bursts are possible with no gap.
- Async rst mid-burst: all outputs 0 immediately, with no done.

## Test plan
- FREE, W=8, up, en=1 from 0 for 256 cycles → count 0..255..0, tc single pulse after 255→0; dir=1 from 0 → 255 with tc.
- MOD, limit=5, up 12 steps → 0,1,2,3,4,5,0,…; tc after each 5→0. load 9, then step down → 5 with tc.
- SAT, limit=3, up 6 steps → 1,2,3,3,3,3; tc once after 2→3. Down to 0 holds; tc once after 1→0.
- BURST, limit=4, up, en=1, start 1 cycle → busy 4 cycles, count 1..4, done+tc 1 cycle, count holds 4. Toggle en mid-burst → busy extends by the number of en-low cycles.
- BURST, limit=0 → no busy, done pulse the next cycle. start while busy → ignored. clr mid-burst → count 0, busy 0, no done.
- Async rst asserted between edges during RUN, and clr+load+start together → reset values; clr wins.
